// File: rtl/fft_frame_collector.sv
// Serial-to-frame collector, ping-pong double buffered, with bit-reversed index table.
// Optional OVERRUN_DROP_EN: drop samples when both buffers are full instead of stalling.
module fft_frame_collector #(
  parameter int SAMPLES = 4,
  parameter int WIDTH   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             in_sample,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [WIDTH-1:0]             frame_data [SAMPLES],
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [$clog2(SAMPLES)-1:0]   bitrev_index [SAMPLES],
  output logic [$clog2(SAMPLES):0]     fill_level,
  output logic                         overrun
);

  localparam int AW = $clog2(SAMPLES);
  localparam logic [AW-1:0] LAST = AW'(SAMPLES - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  logic [WIDTH-1:0] r_buf [2][SAMPLES];
  logic [1:0]       r_full;
  logic             r_wr_sel;
  logic             r_rd_sel;
  logic [AW-1:0]    r_wr_idx;

  logic w_accept;
  logic w_last;
  logic w_take;

`ifdef OVERRUN_DROP_EN
  logic r_overrun;
  logic w_drop;

  assign in_ready = !flush;
  assign w_accept = in_valid && !flush && !r_full[r_wr_sel];
  assign w_drop   = in_valid && !flush && r_full[r_wr_sel];
  assign overrun  = r_overrun;

  // Sticky overrun flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end
`else
  assign in_ready = !r_full[r_wr_sel] && !flush;
  assign w_accept = in_valid && in_ready;
  assign overrun  = 1'b0;
`endif

  assign w_last      = w_accept && (r_wr_idx == LAST);
  assign frame_valid = r_full[r_rd_sel];
  assign w_take      = frame_valid && frame_ready;
  assign fill_level  = {1'b0, r_wr_idx};

  // Write pointer, buffer select and full flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full   <= 2'b00;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_wr_idx <= '0;
    end else begin
      if (w_take) begin
        r_full[r_rd_sel] <= 1'b0;
        r_rd_sel         <= ~r_rd_sel;
      end
      if (flush) begin
        r_wr_idx <= '0;
      end else if (w_last) begin
        r_full[r_wr_sel] <= 1'b1;
        r_wr_sel         <= ~r_wr_sel;
        r_wr_idx         <= '0;
      end else if (w_accept) begin
        r_wr_idx <= r_wr_idx + ONE;
      end
    end
  end

  // Sample storage; cleared on reset so frame_data reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < SAMPLES; k++) begin
          r_buf[b][k] <= '0;
        end
      end
    end else if (w_accept) begin
      r_buf[r_wr_sel][r_wr_idx] <= in_sample;
    end
  end

  // Present the read-side buffer as a parallel frame
  always_comb begin
    for (int k = 0; k < SAMPLES; k++) begin
      frame_data[k] = r_buf[r_rd_sel][k];
    end
  end

  // Constant bit-reversed index table
  for (genvar i = 0; i < SAMPLES; i++) begin : g_rev
    for (genvar b = 0; b < AW; b++) begin : g_bit
      assign bitrev_index[i][b] = 1'((i >> (AW - 1 - b)) & 1);
    end
  end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Self-checking bench for fft_frame_collector (SAMPLES=4, WIDTH=8).
// Reference model keeps pending frames and the partial frame as queues.
module tb_fft_frame_collector;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_sample;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] frame_data [N];
  logic         frame_valid;
  logic         frame_ready;
  logic [1:0]   bitrev_index [N];
  logic [2:0]   fill_level;
  logic         overrun;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]   part [$];
  logic [N*W-1:0] frm  [$];
  bit             ov_exp;

  fft_frame_collector #(.SAMPLES(N), .WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .bitrev_index(bitrev_index),
    .fill_level  (fill_level),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready(input bit fl);
`ifdef OVERRUN_DROP_EN
    return !fl;
`else
    return !fl && (frm.size() < 2);
`endif
  endfunction

  task automatic check_outputs(input bit fl);
    chk("in_ready", 32'(in_ready), 32'(exp_ready(fl)));
    chk("frame_valid", 32'(frame_valid), 32'(frm.size() > 0));
    chk("fill_level", 32'(fill_level), 32'(part.size()));
    chk("overrun", 32'(overrun), 32'(ov_exp));
    if (frm.size() > 0) begin
      for (int k = 0; k < N; k++) begin
        chk($sformatf("frame_data[%0d]", k), 32'(frame_data[k]),
            32'(frm[0][k*W +: W]));
      end
    end
  endtask

  task automatic step(input bit v, input logic [W-1:0] s,
                      input bit fl, input bit fr);
    bit acc;
    bit take;
    in_valid    = v;
    in_sample   = s;
    flush       = fl;
    frame_ready = fr;
    @(negedge clk);
    check_outputs(fl);
    acc  = v && !fl && (frm.size() < 2);
    take = fr && (frm.size() > 0);
`ifdef OVERRUN_DROP_EN
    if (v && !fl && frm.size() == 2) ov_exp = 1'b1;
`endif
    if (take) void'(frm.pop_front());
    if (fl) begin
      part.delete();
    end else if (acc) begin
      part.push_back(s);
      if (part.size() == N) begin
        frm.push_back({part[3], part[2], part[1], part[0]});
        part.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_fill_level", 32'(fill_level), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_frame_data[%0d]", k), 32'(frame_data[k]), 32'd0);
    end
  endtask

  task automatic model_reset();
    part.delete();
    frm.delete();
    ov_exp = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && frm.size() > 0; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("drained", 32'(frm.size()), 32'd0);
  endtask

  initial begin
    logic [1:0] iv;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_sample   = '0;
    flush       = 1'b0;
    frame_ready = 1'b0;
    model_reset();
    #12;
    check_reset_state();
    for (int i = 0; i < N; i++) begin
      iv = 2'(i);
      chk($sformatf("bitrev[%0d]", i), 32'(bitrev_index[i]),
          32'({iv[0], iv[1]}));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic frame with consumer always ready
    for (int x = 1; x <= 4; x++) step(1'b1, W'(x), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // backpressure with both buffers full
    for (int x = 1; x <= 8; x++) step(1'b1, W'(x), 1'b0, 1'b0);
    step(1'b1, 8'd9, 1'b0, 1'b0);
    step(1'b1, 8'd9, 1'b0, 1'b0);
    step(1'b1, 8'd9, 1'b0, 1'b1);
    step(1'b1, 8'd9, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("fill_after_9", 32'(fill_level), 32'd1);
    drain();
    step(1'b1, 8'd10, 1'b1, 1'b0);

    // flush a partial frame
    step(1'b1, 8'd7, 1'b0, 1'b0);
    step(1'b1, 8'd8, 1'b0, 1'b0);
    step(1'b1, 8'd99, 1'b1, 1'b0);
    for (int x = 1; x <= 4; x++) step(1'b1, W'(x), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // last sample of B lands with handshake of A
    for (int x = 11; x <= 13; x++) step(1'b1, W'(x), 1'b0, 1'b0);
    step(1'b1, 8'd14, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    drain();

    // reset with a pending frame and a partial one
    for (int x = 21; x <= 26; x++) step(1'b1, W'(x), 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int x = 31; x <= 34; x++) step(1'b1, W'(x), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), W'($urandom),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) == 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
